mandelbrot_pixel_fetch: RTL and testbench

Requester-side companion to the Mandelbrot engine: drives the engine's one-pixel `run` handshake, captures each finished 4-bit iteration code, and buffers it in a small FIFO. The FIFO feeds the display/readout path through a valid/ready stream. It also tags line and frame boundaries and checks them against the engine's `finished` flag. It sits between the engine and the video output logic.

---
 rtl/mandelbrot_pkg.sv | 28 ++
 rtl/pixel_fifo.sv | 65 ++++++
 rtl/mandelbrot_pixel_fetch.sv | 137 +++++++++++++
 tb/tb_mandelbrot_pixel_fetch.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mandelbrot_pkg.sv
// mandelbrot_pkg
// Shared definitions for the Mandelbrot pixel fetch path: the fetch FSM state encoding, the
// iteration-code width, and the bit layout of a buffered pixel entry {eof, eol, data}.
package mandelbrot_pkg;

  localparam int unsigned CODE_W    = 4;
  localparam int unsigned ENTRY_EOL = 4;
  localparam int unsigned ENTRY_EOF = 5;
  localparam int unsigned ENTRY_W   = 6;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_ISSUE,
    FETCH_WAIT_START,
    FETCH_WAIT_DONE
  } fetch_state_e;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic eof, input logic eol,
                                                    input logic [CODE_W-1:0] data);
    logic [ENTRY_W-1:0] e;
    e = '0;
    e[CODE_W-1:0] = data;
    e[ENTRY_EOL]  = eol;
    e[ENTRY_EOF]  = eof;
    return e;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo
// Show-ahead synchronous FIFO: the head entry is presented combinationally on o_head.
// Ports:
//   clk, rst     clock, synchronous active-high reset (empties the FIFO)
//   i_push       write i_push_data (ignored when full unless a pop happens in the same cycle)
//   i_pop        drop the head entry (ignored when empty)
//   o_head       head entry, forced to zero while empty
//   o_count      number of stored entries (0..DEPTH)
//   o_full       o_count == DEPTH
//   o_empty      o_count == 0
module pixel_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [DW-1:0]          i_push_data,
  input  logic                   i_pop,
  output logic [DW-1:0]          o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FullCount);
  assign o_count   = r_count;
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mandelbrot_pixel_fetch.sv
// mandelbrot_pixel_fetch
// Requests pixels from the Mandelbrot engine one at a time, captures each 4-bit iteration
// code, tags it with line/frame position and buffers it for the video readout stream.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   enable            keep requesting pixels while high
//   eng_run           one-cycle request pulse to the engine
//   eng_running       engine busy
//   eng_ctr           engine iteration code, valid once eng_running falls
//   eng_finished      engine frame-complete flag, checked against our eof tag
//   pix_valid/ready   output stream handshake
//   pix_data/eol/eof  head pixel code and position tags
//   busy              fetch FSM not idle
//   sync_err          sticky frame-boundary mismatch
module mandelbrot_pixel_fetch
  import mandelbrot_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned WIDTH  = 320,
  parameter int unsigned HEIGHT = 240
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              eng_run,
  input  logic              eng_running,
  input  logic [CODE_W-1:0] eng_ctr,
  input  logic              eng_finished,
  output logic              pix_valid,
  output logic [CODE_W-1:0] pix_data,
  output logic              pix_eol,
  output logic              pix_eof,
  input  logic              pix_ready,
  output logic              busy,
  output logic              sync_err
);

  localparam int unsigned XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [XW-1:0] XLast  = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YLast  = YW'(HEIGHT - 1);
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  fetch_state_e       r_state;
  fetch_state_e       w_state_next;
  logic [XW-1:0]      r_x;
  logic [YW-1:0]      r_y;
  logic               r_sync_err;
  logic               w_push;
  logic               w_pop;
  logic               w_eol;
  logic               w_eof;
  logic [CW-1:0]      w_count;
  logic [CW-1:0]      w_post_count;
  logic               w_full;
  logic               w_empty;
  logic [ENTRY_W-1:0] w_head;

  assign w_eol = (r_x == XLast);
  assign w_eof = w_eol && (r_y == YLast);
  assign w_pop = pix_ready && !w_empty;

  // Occupancy as it will be after this cycle's push and any concurrent pop.
  assign w_post_count = w_count + CW'(1) - CW'(w_pop);

  pixel_fifo #(
    .DEPTH (DEPTH),
    .DW    (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (pack_entry(w_eof, w_eol, eng_ctr)),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= FETCH_IDLE;
    else     r_state <= w_state_next;
  end

  // A request is only issued with a free FIFO slot, so the eventual push can never overflow.
  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    eng_run      = 1'b0;
    unique case (r_state)
      FETCH_IDLE: begin
        if (enable && !eng_running && !w_full) w_state_next = FETCH_ISSUE;
      end
      FETCH_ISSUE: begin
        eng_run      = 1'b1;
        w_state_next = FETCH_WAIT_START;
      end
      FETCH_WAIT_START: begin
        if (eng_running) w_state_next = FETCH_WAIT_DONE;
      end
      FETCH_WAIT_DONE: begin
        if (!eng_running) begin
          w_push = 1'b1;
          if (enable && (w_post_count < DepthC)) w_state_next = FETCH_ISSUE;
          else                                   w_state_next = FETCH_IDLE;
        end
      end
      default: w_state_next = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x        <= '0;
      r_y        <= '0;
      r_sync_err <= 1'b0;
    end else if (w_push) begin
      if (w_eol) begin
        r_x <= '0;
        r_y <= w_eof ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
      if (eng_finished != w_eof) r_sync_err <= 1'b1;
    end
  end

  assign pix_valid = !w_empty;
  assign pix_data  = w_head[CODE_W-1:0];
  assign pix_eol   = w_head[ENTRY_EOL];
  assign pix_eof   = w_head[ENTRY_EOF];
  assign busy      = (r_state != FETCH_IDLE);
  assign sync_err  = r_sync_err;

endmodule

// File: tb/tb_mandelbrot_pixel_fetch.sv
module tb_mandelbrot_pixel_fetch;

  localparam int D       = 8;
  localparam int W       = 4;
  localparam int H       = 2;
  localparam int Compute = 5;
  localparam logic [3:0] Codes [16] = '{4'h7, 4'hF, 4'h0, 4'h3, 4'hA, 4'h1, 4'hC, 4'h5,
                                        4'h9, 4'h2, 4'hE, 4'h4, 4'h8, 4'hB, 4'h6, 4'hD};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       pix_ready = 1'b1;
  logic       eng_run;
  logic       eng_running = 1'b0;
  logic [3:0] eng_ctr = 4'h0;
  logic       eng_finished = 1'b0;
  logic       pix_valid;
  logic [3:0] pix_data;
  logic       pix_eol;
  logic       pix_eof;
  logic       busy;
  logic       sync_err;

  int nvec = 0;
  int nerr = 0;
  int pops = 0;
  int run_pulses = 0;

  logic       bad_mode = 1'b0;
  logic [5:0] exp_q [$];
  int         code_idx = 0;
  int         m_cnt = 0;
  int         exp_x = 0;
  int         exp_y = 0;
  logic       m_discard = 1'b0;
  logic       m_eol;
  logic       m_eof;
  logic       m_fin;

  logic       prev_run = 1'b0;
  logic       prev_stall = 1'b0;
  logic [5:0] prev_out = '0;
  logic [5:0] got;
  logic [5:0] want;

  mandelbrot_pixel_fetch #(
    .DEPTH  (D),
    .WIDTH  (W),
    .HEIGHT (H)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .eng_run      (eng_run),
    .eng_running  (eng_running),
    .eng_ctr      (eng_ctr),
    .eng_finished (eng_finished),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_eol      (pix_eol),
    .pix_eof      (pix_eof),
    .pix_ready    (pix_ready),
    .busy         (busy),
    .sync_err     (sync_err)
  );

  always #5 clk = ~clk;

  // Expected tags for the pixel the engine is currently computing.
  assign m_eol = (exp_x == W - 1);
  assign m_eof = m_eol && (exp_y == H - 1);
  // Bad mode raises finished on the 5th pixel of the frame instead of the last.
  assign m_fin = bad_mode ? (exp_x == 0 && exp_y == 1) : m_eof;

  // Engine model: run -> running for Compute cycles -> code valid as running falls.
  always @(posedge clk) begin
    if (eng_run) begin
      eng_running <= 1'b1;
      m_cnt       <= Compute;
    end else if (eng_running) begin
      if (m_cnt == 1) begin
        eng_running  <= 1'b0;
        eng_ctr      <= Codes[code_idx];
        eng_finished <= m_fin;
        code_idx     <= (code_idx + 1) % 16;
        if (!m_discard) begin
          exp_q.push_back({m_eof, m_eol, Codes[code_idx]});
          if (m_eol) begin
            exp_x <= 0;
            exp_y <= m_eof ? 0 : exp_y + 1;
          end else begin
            exp_x <= exp_x + 1;
          end
        end
        m_discard <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
    if (rst) begin
      exp_x <= 0;
      exp_y <= 0;
      exp_q.delete();
      // A pixel still in flight across our reset is never pushed by the DUT.
      m_discard <= eng_running && (m_cnt != 1);
    end
  end

  // Monitor: request protocol, stall stability, and scoreboard pops.
  initial begin
    forever begin
      @(negedge clk);
      got = {pix_eof, pix_eol, pix_data};
      if (eng_run) begin
        run_pulses++;
        nvec++;
        if (prev_run || eng_running) begin
          nerr++;
          $display("FAIL eng_run_protocol: prev_run=%0b running=%0b, required 0 0",
                   prev_run, eng_running);
        end
      end
      if (!rst && prev_stall) begin
        nvec++;
        if (!pix_valid || got != prev_out) begin
          nerr++;
          $display("FAIL stall_hold: valid=%0b out=%h, required valid=1 out=%h",
                   pix_valid, got, prev_out);
        end
      end
      if (!rst && pix_valid && pix_ready) begin
        pops++;
        nvec++;
        if (exp_q.size() == 0) begin
          nerr++;
          $display("FAIL pop_unexpected: out=%h, required no pixel", got);
        end else begin
          want = exp_q.pop_front();
          if (got != want) begin
            nerr++;
            $display("FAIL pixel_%0d: {eof,eol,data}=%h, required %h", pops, got, want);
          end
        end
      end
      prev_run   = eng_run;
      prev_stall = !rst && pix_valid && !pix_ready;
      prev_out   = got;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_pops(input string name, input int target, input int budget);
    int t = 0;
    while (pops < target && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    nvec++;
    if (pops < target) begin
      nerr++;
      $display("FAIL %s: pops=%0d after %0d cycles, required %0d", name, pops, t, target);
    end
  endtask

  // sel 0 watches busy, sel 1 watches eng_running.
  task automatic wait_level(input string name, input int sel, input logic val, input int budget);
    int t = 0;
    while (((sel == 0) ? busy : eng_running) !== val && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    nvec++;
    if (((sel == 0) ? busy : eng_running) !== val) begin
      nerr++;
      $display("FAIL %s: level=%0b after %0d cycles, required %0b",
               name, ((sel == 0) ? busy : eng_running), t, val);
    end
  endtask

  initial begin
    int p;
    int r;

    cyc(3);
    rst = 1'b0;
    check("rst_eng_run", eng_run, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_data", pix_data, 0);
    check("rst_pix_eol", pix_eol, 0);
    check("rst_pix_eof", pix_eof, 0);
    check("rst_busy", busy, 0);
    check("rst_sync_err", sync_err, 0);

    // Free-running stream over two frames.
    enable = 1'b1;
    p = pops;
    wait_pops("stream", p + 16, 600);
    check("stream_sync_err", sync_err, 0);

    // Backpressure: FIFO fills to DEPTH, then issue stops.
    enable = 1'b0;
    wait_level("idle_before_stall", 0, 1'b0, 60);
    cyc(4);
    check("empty_before_stall", pix_valid, 0);
    pix_ready = 1'b0;
    r = run_pulses;
    enable = 1'b1;
    cyc(150);
    check("stall_issue_count", run_pulses - r, 8);
    check("stall_valid", pix_valid, 1);
    check("stall_busy", busy, 0);
    p = pops;
    r = run_pulses;
    pix_ready = 1'b1;
    cyc(1);
    pix_ready = 1'b0;
    cyc(40);
    check("single_pop", pops - p, 1);
    check("refill_issue", run_pulses - r, 1);
    enable = 1'b0;
    pix_ready = 1'b1;
    wait_level("idle_after_stall", 0, 1'b0, 30);
    cyc(12);
    check("drained", pix_valid, 0);

    // Drop enable mid-compute: pixel still lands, FSM parks.
    enable = 1'b1;
    wait_level("run_rise", 1, 1'b1, 20);
    cyc(2);
    enable = 1'b0;
    p = pops;
    wait_level("park_idle", 0, 1'b0, 30);
    cyc(4);
    check("inflight_pushed", pops - p, 1);
    check("parked_busy", busy, 0);

    // Resume mid-frame with a misplaced finished flag, then clean frames.
    check("sync_err_before_bad", sync_err, 0);
    bad_mode = 1'b1;
    enable = 1'b1;
    p = pops;
    wait_pops("bad_frame", p + 8, 300);
    bad_mode = 1'b0;
    check("sync_err_set", sync_err, 1);
    p = pops;
    wait_pops("good_after_bad", p + 16, 400);
    check("sync_err_sticky", sync_err, 1);

    // Reset while the engine is computing.
    wait_level("engine_gap", 1, 1'b0, 30);
    wait_level("run_before_rst", 1, 1'b1, 30);
    cyc(1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("post_rst_valid", pix_valid, 0);
    check("post_rst_sync_err", sync_err, 0);
    check("post_rst_busy", busy, 0);
    r = run_pulses;
    wait_level("engine_drains", 1, 1'b0, 20);
    check("no_issue_while_running", run_pulses - r, 0);
    p = pops;
    wait_pops("post_rst_frame", p + 8, 300);
    check("post_rst_frame_sync", sync_err, 0);

    enable = 1'b0;
    wait_level("final_idle", 0, 1'b0, 30);
    cyc(12);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

endmodule
